// File: rtl/bcd_conv_arbiter_pkg.sv
// ============================================================================
// Module      : bcd_conv_arbiter_pkg
// Description : Shared types, default constants and nibble-adjust helper for
//               the shared binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_conv_arbiter_pkg;

    localparam int c_N_REQ_DEF  = 4;
    localparam int c_BIN_W_DEF  = 16;
    localparam int c_DIGITS_DEF = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Double-dabble correction applied before every shift.
    function automatic logic [3:0] nibble_adj(input logic [3:0] i_nib);
        return (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_conv_arbiter_if.sv
// ============================================================================
// Module      : bcd_conv_arbiter_if
// Description : Request/response bus between requesters and the shared
//               BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_conv_arbiter_if
    import bcd_conv_arbiter_pkg::*;
#(
    parameter int N_REQ  = c_N_REQ_DEF,
    parameter int BIN_W  = c_BIN_W_DEF,
    parameter int DIGITS = c_DIGITS_DEF
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*BIN_W-1:0] req_data;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [4*DIGITS-1:0]    rsp_bcd;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_bcd
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_bcd
    );

endinterface

`default_nettype wire

// File: rtl/bcd_conv_arbiter_dabble_core.sv
// ============================================================================
// Module      : bcd_dabble_core
// Description : Iterative shift-add-3 engine, one iteration per enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_dabble_core
    import bcd_conv_arbiter_pkg::*;
#(
    parameter int BIN_W  = c_BIN_W_DEF,
    parameter int DIGITS = c_DIGITS_DEF
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                i_load,
    input  wire logic [BIN_W-1:0]    i_operand,
    input  wire logic                i_step,
    output logic                     o_done,
    output logic [4*DIGITS-1:0]      o_bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [SH_W-1:0]  r_sh;
    logic [CNT_W-1:0] r_cnt;
    logic [SH_W-1:0]  w_adj;
    logic [SH_W-1:0]  w_next;

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_adj
            assign w_adj[BIN_W + 4*d +: 4] = nibble_adj(r_sh[BIN_W + 4*d +: 4]);
        end
    endgenerate

    assign w_adj[BIN_W-1:0] = r_sh[BIN_W-1:0];
    assign w_next           = w_adj << 1;

    // o_bcd is the value the register takes on the final step edge.
    assign o_done = i_step && (r_cnt == CNT_W'(BIN_W - 1));
    assign o_bcd  = w_next[SH_W-1 -: BCD_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= {{BCD_W{1'b0}}, i_operand};
            r_cnt <= '0;
        end else if (i_step) begin
            r_sh  <= w_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_conv_arbiter.sv
// ============================================================================
// Module      : bcd_conv_arbiter
// Description : Round-robin arbiter sharing one double-dabble BCD engine
//               among N_REQ requesters; results are tagged with requester ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_conv_arbiter
    import bcd_conv_arbiter_pkg::*;
#(
    parameter int N_REQ  = c_N_REQ_DEF,
    parameter int BIN_W  = c_BIN_W_DEF,
    parameter int DIGITS = c_DIGITS_DEF
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    bcd_conv_arbiter_if.slave    bus
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int BCD_W = 4 * DIGITS;

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic               r_rsp_valid;
    logic [BCD_W-1:0]   r_rsp_bcd;

    logic               w_found;
    logic [ID_W-1:0]    w_gnt;
    logic [ID_W:0]      w_sum;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_ptr_next;
    logic               w_load;
    logic               w_done;
    logic [BCD_W-1:0]   w_bcd;
    logic [BIN_W-1:0]   w_operand;

    // First valid requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(N_REQ);
            end
            w_idx = w_sum[ID_W-1:0];
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    assign w_ptr_next = (w_gnt == ID_W'(N_REQ - 1)) ? '0 : (w_gnt + 1'b1);
    assign w_load     = (r_state == S_IDLE) && w_found;
    assign w_operand  = bus.req_data[int'(w_gnt)*BIN_W +: BIN_W];

    assign bus.req_ready = (rst_n && w_load) ? (N_REQ'(1) << w_gnt) : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_bcd   = r_rsp_bcd;

    bcd_dabble_core #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_operand (w_operand),
        .i_step    (r_state == S_CONV),
        .o_done    (w_done),
        .o_bcd     (w_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_bcd   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_CONV;
                        r_id    <= w_gnt;
                        r_ptr   <= w_ptr_next;
                    end
                end
                S_CONV: begin
                    if (w_done) begin
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_bcd   <= w_bcd;
                    end
                end
                S_DONE: begin
                    // Returning through IDLE keeps the accept edge free of new grants.
                    if (bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
// ============================================================================
// Module      : tb_bcd_conv_arbiter
// Description : Scoreboard bench for the shared BCD converter arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_conv_arbiter;
    import bcd_conv_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 16;
    localparam int D = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_conv_arbiter_if #(.N_REQ(N), .BIN_W(W), .DIGITS(D)) bus ();

    bcd_conv_arbiter #(.N_REQ(N), .BIN_W(W), .DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  id;
        logic [19:0] bcd;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] op   [N];
    bit          pend [N];
    int          m_ptr   = 0;
    bit          m_busy  = 0;
    int          m_cnt   = 0;
    int          rsp_mode = 0;
    bit          soak_en = 0;
    int          repend_left = 0;
    int          granted = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < D; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int mgrant();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]         = pend[i];
            bus.req_data[i*W +: W]   = op[i];
        end
    endtask

    // One clock: check grant against the round-robin model, then update stimulus.
    task automatic step();
        int g;
        bit rel;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        g = -1;
        rel = 1'b0;
        exp_rdy = '0;
        if (!m_busy) begin
            g = mgrant();
            if (g >= 0) exp_rdy[g] = 1'b1;
        end else begin
            m_cnt++;
            if (m_cnt >= W + 1 && bus.rsp_ready) rel = 1'b1;
        end
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (g >= 0) begin
            exp_q.push_back('{g[1:0], ref_bcd(int'(op[g]))});
            lat_q.push_back(cyc);
            m_busy = 1'b1;
            m_cnt  = 0;
            m_ptr  = (g + 1) % N;
            granted++;
        end
        @(posedge clk);
        #1;
        if (g >= 0) begin
            pend[g] = 1'b0;
            if (repend_left > 0) begin
                repend_left--;
                pend[g] = 1'b1;
                op[g]   = op[g] + 16'd4;
            end
        end
        if (rel) m_busy = 1'b0;
        case (rsp_mode)
            1:       bus.rsp_ready = !(m_busy && m_cnt >= W && m_cnt < W + 10);
            2:       bus.rsp_ready = 1'($urandom_range(0, 1));
            default: bus.rsp_ready = 1'b1;
        endcase
        if (soak_en) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    op[i]   = 16'($urandom_range(0, 65535));
                end
            end
        end
        drive_bus();
    endtask

    task automatic run_idle(input int maxc);
        int n;
        n = 0;
        while ((m_busy || any_pend()) && n < maxc) begin
            step();
            n++;
        end
        check("run_timeout", 32'(m_busy || any_pend()), 32'd0);
    endtask

    task automatic single(input int r, input int v);
        pend[r] = 1'b1;
        op[r]   = 16'(v);
        drive_bus();
        run_idle(100);
    endtask

    // Response monitor: latency, hold-under-backpressure and scoreboard compare.
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [19:0] hold_bcd;
    logic [1:0]  hold_id;
    int          t_acc;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus.rsp_valid && !prev_v) begin
                check("lat_q_nonempty", 32'(lat_q.size() > 0), 32'd1);
                if (lat_q.size() > 0) begin
                    t_acc = lat_q.pop_front();
                    check("latency", 32'(cyc - t_acc), 32'(W + 1));
                end
            end
            if (bus.rsp_valid && prev_v && !prev_r) begin
                check("hold_bcd", 32'(bus.rsp_bcd), 32'(hold_bcd));
                check("hold_id", 32'(bus.rsp_id), 32'(hold_id));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    check("rsp_bcd", 32'(bus.rsp_bcd), 32'(e.bcd));
                end
            end
            prev_v   = bus.rsp_valid;
            prev_r   = bus.rsp_ready;
            hold_bcd = bus.rsp_bcd;
            hold_id  = bus.rsp_id;
        end
    end

    initial begin
        int target;
        int n;

        // Reset with all requesters already asserting operands 0..3.
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            op[i]   = 16'(i);
        end
        bus.rsp_ready = 1'b1;
        drive_bus();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_bcd", 32'(bus.rsp_bcd), 32'd0);
        check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round-robin: grants 0,1,2,3 then again with operands 4..7.
        repend_left = 4;
        run_idle(400);

        // Directed single requests and boundary values.
        single(2, 1234);
        single(0, 0);
        single(1, 9);
        single(3, 10);
        single(2, 9999);
        single(1, 65535);

        // Backpressure: rsp_ready low for 10 cycles, second request waits.
        rsp_mode = 1;
        pend[1] = 1'b1; op[1] = 16'd4321;
        pend[3] = 1'b1; op[3] = 16'd77;
        drive_bus();
        run_idle(200);
        rsp_mode = 0;

        // Reset in the middle of a conversion.
        pend[2] = 1'b1; op[2] = 16'd4321;
        drive_bus();
        step();
        pend[0] = 1'b1; op[0] = 16'd500;
        pend[3] = 1'b1; op[3] = 16'd42;
        drive_bus();
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midreset_rsp_bcd", 32'(bus.rsp_bcd), 32'd0);
        check("midreset_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("midreset_req_ready", 32'(bus.req_ready), 32'd0);
        exp_q.delete();
        lat_q.delete();
        m_busy = 1'b0;
        m_cnt  = 0;
        m_ptr  = 0;
        repeat (2) begin
            @(negedge clk);
            check("inreset_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_idle(200);

        // Random soak with random backpressure.
        soak_en  = 1'b1;
        rsp_mode = 2;
        target   = granted + 1000;
        n = 0;
        while (granted < target && n < 60000) begin
            step();
            n++;
        end
        check("soak_done", 32'(granted >= target), 32'd1);
        soak_en  = 1'b0;
        rsp_mode = 0;
        bus.rsp_ready = 1'b1;
        run_idle(400);
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Shares one iterative double-dabble (shift-add-3) binary-to-BCD engine among several requesters, such as the KPN process nodes that each need a decimal value for display. The block grants requests round-robin, runs one shift-add-3 iteration per clock for BIN_W cycles, and returns the packed BCD result tagged with the requester ID. It sits between the processing nodes and the display/readout logic, so the design does not need one combinational converter per channel.

## Interface
- N_REQ, default 4: number of requesters; must be at least 2.
- BIN_W, default 16: binary operand width.
- DIGITS, default 5: BCD output digits; must satisfy 10^DIGITS > 2^BIN_W − 1.
- clk  in  1: clock; all state updates on rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- req_valid  in  N_REQ: per-requester request valid.
- req_ready  out  N_REQ: per-requester accept; one-hot or zero.
- req_data  in  N_REQ*BIN_W: operands, with requester i at bits [i*BIN_W +: BIN_W].
- rsp_valid  out  1: result valid.
- rsp_ready  in  1: downstream accepts result.
- rsp_id  out  clog2(N_REQ): index of the requester that owns the result.
- rsp_bcd  out  4*DIGITS: packed BCD, most significant digit at the top.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - If any req_valid is high, the round-robin winner g sees req_ready[g] = 1. req_ready is combinational from req_valid and the pointer.
  - On the handshake edge, the block latches the operand into a (4*DIGITS + BIN_W)-bit shift register with the BCD field cleared.
  - It also latches g into the ID register, clears the iteration counter, and goes to CONV.
- Round-robin:
  - The pointer holds the highest-priority index.
  - The search runs ptr, ptr+1, … with wrap-around modulo N_REQ.
  - After a grant to g, ptr becomes (g+1) mod N_REQ.
  - The pointer is unchanged when nothing is granted.
- CONV, each cycle:
  - Every BCD nibble ≥ 5 gets +3 (4-bit result).
  - Then the whole register shifts left by 1.
  - The counter increments. When the counter equals BIN_W−1 at the edge, the block goes to DONE and registers rsp_valid = 1.
- DONE:
  - rsp_bcd, rsp_id and rsp_valid hold stable while rsp_ready = 0.
  - On the edge with rsp_ready = 1 the block goes to IDLE and rsp_valid drops.
  - No new request is accepted in that same cycle.
- req_ready is 0 in CONV and DONE. Requesters must hold req_valid and req_data until accepted.
- Operand width is exact: no truncation. The top nibble never exceeds the decimal value's digit count.

## Timing
- Reset values: state IDLE, ptr 0, rsp_valid 0, rsp_bcd 0, rsp_id 0, counter 0. req_ready is 0 while rst_n is low.
- Latency: request handshake at edge E0, then rsp_valid is high from edge E(BIN_W) onwards (16 cycles at the defaults).
- Throughput: at most one conversion per BIN_W+2 cycles with rsp_ready tied high.
- A request arriving while the block is busy waits. A request that drops before acceptance is simply lost, with no side effect.
- Simultaneous req_valid on all lines: exactly one grant per IDLE visit, in pointer order.
- Reset asserted mid-CONV or mid-DONE: immediate return to the reset values. The in-flight result is discarded and never presented.
- rsp_ready high while rsp_valid is low is ignored.

## Structure
- Shared package holds:
  - FSM state typedef (IDLE/CONV/DONE).
  - Default parameter constants.
  - A function computing the nibble adjust (+3 if ≥ 5).
- One sub-module, bcd_dabble_core, contains the shift register, counter and adjust logic. Its interface is load/operand in, done/bcd out.
- The arbiter, FSM and response registers stay in bcd_conv_arbiter.

## Test plan
- Single request: requester 2 sends 1234 with rsp_ready high. Expect rsp_bcd = 0x01234, rsp_id = 2, rsp_valid exactly 16 cycles after acceptance.
- Boundary values:
  - 0 → 0x00000
  - 9 → 0x00009
  - 10 → 0x00010
  - 9999 → 0x09999
  - 65535 → 0x65535
- Round-robin: all 4 requesters hold req_valid from reset with operands 0, 1, 2, 3. Grants come in order 0, 1, 2, 3, 0…, with rsp_id matching each one.
- Backpressure: rsp_ready held low for 10 cycles after rsp_valid. Result and ID stay stable, req_ready stays 0, and the next grant follows only after the accepting edge.
- Reset mid-conversion: rst_n pulsed low 5 cycles into CONV. All outputs return to 0 asynchronously, no response is emitted, and the next grant goes to requester 0.
- Random soak: 1000 random operands and requester patterns, with each rsp_bcd checked against a decimal reference model and rsp_id ordering checked against a round-robin model.
